// File: rtl/uart_pkg.sv
// Shared defaults and state encoding for the UART TX byte arbiter.
package uart_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_MAX_BURST    = 16;
  localparam int unsigned DEF_IDLE_TIMEOUT = 255;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus TX FIFO write port of the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = uart_pkg::DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    full_TX;
  logic                    we_TX;
  logic [7:0]              wdata_TX;
  logic [1:0]              grant_id;
  logic                    busy;

  modport slave (
    input  req_valid, req_data, req_last, full_TX,
    output req_ready, we_TX, wdata_TX, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, full_TX,
    input  req_ready, we_TX, wdata_TX, grant_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick over 4 requesters, starting after last_owner.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last_owner,
  output logic [1:0] index,
  output logic       any
);

  logic [1:0] cand;

  // Offsets walk from 4 (last_owner itself) down to 1; the last hit wins,
  // so last_owner+1 has highest priority and last_owner the lowest.
  always_comb begin
    index = '0;
    cand  = '0;
    any   = |req;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = last_owner + 2'(4 - k);
      if (req[cand]) index = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one byte requester at a time onto the TX FIFO.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic               PCLK,
  input  logic               PRESET,
  uart_tx_arbiter_if.slave   bus
);

  localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t         state;
  logic [1:0]         grant_q;
  logic [1:0]         last_owner;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic [1:0] pick_idx;
  logic       pick_any;
  logic       lock;
  logic       own_valid;
  logic       xfer;
  logic       burst_done;
  logic       timeout;
  logic       release_grant;

  rr_pick u_rr_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner),
    .index      (pick_idx),
    .any        (pick_any)
  );

  assign lock       = (state == ST_LOCK);
  assign own_valid  = bus.req_valid[grant_q];
  assign xfer       = lock && own_valid && !bus.full_TX;
  assign burst_done = (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign timeout    = (stall_cnt == STALL_W'(IDLE_TIMEOUT - 1));

  // Last-byte and burst-limit release share one term so they fire only once.
  assign release_grant = (xfer && (bus.req_last[grant_q] || burst_done)) ||
                         (lock && !own_valid && timeout);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      last_owner <= 2'd3;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_idx;
            state     <= ST_LOCK;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        ST_LOCK: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (own_valid) stall_cnt <= '0;
          else           stall_cnt <= stall_cnt + 1'b1;
          if (release_grant) begin
            state      <= ST_IDLE;
            last_owner <= grant_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready          = '0;
    bus.req_ready[grant_q] = xfer;
    bus.we_TX              = xfer;
    bus.wdata_TX           = lock ? bus.req_data[grant_q] : '0;
    bus.grant_id           = grant_q;
    bus.busy               = lock;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic vs a behavioural model.
module tb_uart_tx_arbiter;

  localparam int MB = 16;
  localparam int TO = 255;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the link, who owned it last, bytes and quiet cycles so far.
  bit         m_lock;
  int         m_own;
  int         m_prev;
  int         m_beats;
  int         m_idle;
  logic [3:0] m_xfer_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lock = 0; m_own = 0; m_prev = 3; m_beats = 0; m_idle = 0; m_xfer_mask = '0;
  endfunction

  function automatic void model_release();
    m_lock = 0;
    m_prev = m_own;
  endfunction

  function automatic void model_step();
    bit xfer;
    m_xfer_mask = '0;
    if (!m_lock) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_prev + k) % 4;
        if (bus.req_valid[c]) begin
          m_own = c; m_lock = 1; m_beats = 0; m_idle = 0;
          break;
        end
      end
    end else begin
      xfer = bus.req_valid[m_own] && !bus.full_TX;
      if (xfer) begin
        m_xfer_mask[m_own] = 1'b1;
        m_beats++;
        m_idle = 0;
        if (bus.req_last[m_own] || m_beats == MB) model_release();
      end else if (!bus.req_valid[m_own]) begin
        m_idle++;
        if (m_idle == TO) model_release();
      end else begin
        m_idle = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    logic        xfer;
    logic [31:0] rdy;
    xfer = m_lock && bus.req_valid[m_own] && !bus.full_TX;
    rdy  = xfer ? (32'd1 << m_own) : 32'd0;
    check_eq("busy",      bus.busy,      32'(m_lock));
    check_eq("grant_id",  bus.grant_id,  m_own);
    check_eq("we_TX",     bus.we_TX,     32'(xfer));
    check_eq("req_ready", bus.req_ready, rdy);
    check_eq("wdata_TX",  bus.wdata_TX,  m_lock ? 32'(bus.req_data[m_own]) : 32'd0);
  endtask

  // Called at a falling edge with inputs already applied; ends at the next falling edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(negedge PCLK);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.full_TX   = f;
  endtask

  initial begin
    int         rem [4];
    logic [7:0] cur [4];
    int         wcount;

    PRESET = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.full_TX = 1'b0;
    bus.req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    model_reset();
    @(negedge PCLK);

    // Outputs stay quiet under reset even with requests pending.
    drive(4'b1111, 4'b1111, 1'b0);
    #1;
    check_eq("rst_busy",  bus.busy,      0);
    check_eq("rst_we",    bus.we_TX,     0);
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_wdata", bus.wdata_TX,  0);
    check_eq("rst_grant", bus.grant_id,  0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Requesters 0 and 2 both pending: 0 first, then 2.
    drive(4'b0101, 4'b0101, 1'b0);
    cycle();
    check_eq("t1_busy", bus.busy, 1);
    check_eq("t1_grant0", bus.grant_id, 0);
    cycle();
    cycle();
    check_eq("t1_grant2", bus.grant_id, 2);
    check_eq("t1_busy2", bus.busy, 1);
    drive(4'b0100, 4'b0100, 1'b0);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();

    // Requester 1 sends A1,A2,A3 back to back.
    drive(4'b0010, 4'b0000, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      bus.req_data[1] = 8'hA1 + 8'(i);
      bus.req_last[1] = (i == 2);
      #1;
      check_eq("t2_we", bus.we_TX, 1);
      check_eq("t2_data", bus.wdata_TX, 32'(8'hA1 + 8'(i)));
      cycle();
    end
    drive(4'b0000, 4'b0000, 1'b0);
    #1;
    check_eq("t2_busy_drop", bus.busy, 0);
    cycle();

    // Requester 0 streams without last; burst limit hands over to requester 3.
    drive(4'b0001, 4'b0000, 1'b0);
    cycle();
    drive(4'b1001, 4'b0000, 1'b0);
    for (int i = 0; i < 20 && bus.busy; i++) begin
      bus.req_data[0] = 8'(i);
      cycle();
    end
    check_eq("t3_released", bus.busy, 0);
    check_eq("t3_beats", m_beats, MB);
    cycle();
    check_eq("t3_grant3", bus.grant_id, 3);
    drive(4'b1000, 4'b1000, 1'b0);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();

    // Backpressure mid-packet on requester 2.
    wcount = 0;
    drive(4'b0100, 4'b0000, 1'b0);
    cycle();
    for (int i = 0; i < 11; i++) begin
      bus.full_TX     = (i >= 2 && i < 7);
      bus.req_data[2] = 8'h50 + 8'(i);
      bus.req_last[2] = (i == 8);
      #1;
      if (bus.full_TX) begin
        check_eq("t4_we_full", bus.we_TX, 0);
        check_eq("t4_ready_full", bus.req_ready, 0);
        check_eq("t4_busy_full", bus.busy, 1);
      end
      if (bus.we_TX) wcount++;
      cycle();
      if (i == 8) drive(4'b0000, 4'b0000, 1'b0);
    end
    check_eq("t4_bytes", wcount, 4);

    // Owner 0 goes silent while requester 1 waits: forced release after TO quiet cycles.
    drive(4'b0001, 4'b0000, 1'b0);
    cycle();
    cycle();
    drive(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle();
    check_eq("t5_still_busy", bus.busy, 1);
    cycle();
    check_eq("t5_timeout", bus.busy, 0);
    cycle();
    check_eq("t5_next_grant", bus.grant_id, 1);
    drive(4'b0010, 4'b0010, 1'b0);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();

    // Reset pulse in the middle of a packet from requester 2.
    drive(4'b0100, 4'b0000, 1'b0);
    cycle();
    cycle();
    #2;
    PRESET = 1'b1;
    #1;
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_we", bus.we_TX, 0);
    check_eq("t6_ready", bus.req_ready, 0);
    model_reset();
    @(negedge PCLK);
    PRESET = 1'b0;
    drive(4'b1111, 4'b1111, 1'b0);
    cycle();
    check_eq("t6_grant0", bus.grant_id, 0);
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    cycle();

    // Randomized packets from all requesters with random stalls and backpressure.
    for (int i = 0; i < 4; i++) begin rem[i] = 0; cur[i] = '0; end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0 && $urandom_range(7) == 0) begin
          rem[i] = $urandom_range(20, 1);
          cur[i] = 8'($urandom);
        end
        bus.req_valid[i] = (rem[i] > 0) && ($urandom_range(4) != 0);
        bus.req_data[i]  = bus.req_valid[i] ? cur[i] : 8'($urandom);
        bus.req_last[i]  = (rem[i] == 1);
      end
      bus.full_TX = ($urandom_range(4) == 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
        if (m_xfer_mask[i]) begin
          rem[i]--;
          cur[i] = 8'($urandom);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
